// File: rtl/store_rmw_unit_pkg.sv
// rtl/store_rmw_unit_pkg.sv - shared size encodings, FSM state codes and alignment helper
package store_rmw_unit_pkg;

    typedef logic [1:0] size_t;

    localparam size_t SZ_BYTE = 2'b00;
    localparam size_t SZ_HALF = 2'b01;
    localparam size_t SZ_WORD = 2'b10;
    localparam size_t SZ_RSVD = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    // Reserved size is reported through the same error path as misalignment.
    function automatic logic is_misaligned(input size_t size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = lo[0];
            SZ_WORD: is_misaligned = (lo != 2'b00);
            default: is_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/store_rmw_unit_lane_merge.sv
// rtl/store_rmw_unit_lane_merge.sv - big-endian byte/half/word merge of store data into an old word
module store_lane_merge
    import store_rmw_unit_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] data,
    input  logic [1:0]  size,
    input  logic [1:0]  lo,
    output logic [31:0] merged,
    output logic        misalign
);

    always_comb begin
        merged   = old_word;
        misalign = is_misaligned(size, lo);
        case (size)
            SZ_BYTE: begin
                case (lo)
                    2'd0:    merged[31:24] = data[7:0];
                    2'd1:    merged[23:16] = data[7:0];
                    2'd2:    merged[15:8]  = data[7:0];
                    default: merged[7:0]   = data[7:0];
                endcase
            end
            SZ_HALF: begin
                if (lo[1])
                    merged[15:0] = data[15:0];
                else
                    merged[31:16] = data[15:0];
            end
            SZ_WORD: merged = data;
            default: merged = old_word;
        endcase
    end

endmodule

// File: rtl/store_rmw_unit.sv
// rtl/store_rmw_unit.sv - narrows register stores and writes them to word-only memory via read-modify-write
module store_rmw_unit
    import store_rmw_unit_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    input  logic [1:0]        st_size,
    output logic              st_busy,
    output logic              st_done,
    output logic              st_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    logic [1:0]    state;
    logic [1:0]    lo_q;
    logic [1:0]    size_q;
    logic [31:0]   data_q;
    logic [TW-1:0] timer;

    logic [1:0]    m_size;
    logic [1:0]    m_lo;
    logic [31:0]   merged;
    logic          misalign;
    logic          timed_out;

    // In IDLE the merge unit only screens the incoming request; afterwards it works on the latched one.
    assign m_size    = (state == ST_IDLE) ? st_size : size_q;
    assign m_lo      = (state == ST_IDLE) ? st_addr[1:0] : lo_q;
    assign timed_out = (TIMEOUT != 0) && (timer == TLAST);

    store_lane_merge u_merge (
        .old_word (mem_rdata),
        .data     (data_q),
        .size     (m_size),
        .lo       (m_lo),
        .merged   (merged),
        .misalign (misalign)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            lo_q      <= 2'b00;
            size_q    <= SZ_BYTE;
            data_q    <= 32'd0;
            timer     <= '0;
            st_busy   <= 1'b0;
            st_done   <= 1'b0;
            st_err    <= 1'b0;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_wdata <= 32'd0;
        end else begin
            st_done <= 1'b0;
            st_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (st_req) begin
                        lo_q     <= st_addr[1:0];
                        size_q   <= st_size;
                        data_q   <= st_data;
                        mem_addr <= {st_addr[ADDR_W-1:2], 2'b00};
                        timer    <= '0;
                        if (misalign) begin
                            st_err <= 1'b1;
                        end else if (st_size == SZ_WORD) begin
                            state     <= ST_WRITE;
                            st_busy   <= 1'b1;
                            mem_wr    <= 1'b1;
                            mem_wdata <= st_data;
                        end else begin
                            state   <= ST_READ;
                            st_busy <= 1'b1;
                            mem_rd  <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (mem_ack) begin
                        state     <= ST_WRITE;
                        mem_rd    <= 1'b0;
                        mem_wr    <= 1'b1;
                        mem_wdata <= merged;
                        timer     <= '0;
                    end else if (timed_out) begin
                        state   <= ST_IDLE;
                        mem_rd  <= 1'b0;
                        st_busy <= 1'b0;
                        st_err  <= 1'b1;
                    end else if (TIMEOUT != 0) begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (mem_ack) begin
                        state   <= ST_IDLE;
                        mem_wr  <= 1'b0;
                        st_busy <= 1'b0;
                        st_done <= 1'b1;
                    end else if (timed_out) begin
                        state   <= ST_IDLE;
                        mem_wr  <= 1'b0;
                        st_busy <= 1'b0;
                        st_err  <= 1'b1;
                    end else if (TIMEOUT != 0) begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    mem_rd  <= 1'b0;
                    mem_wr  <= 1'b0;
                    st_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
